// File: rtl/bp_pkg.sv
// Shared types and defaults for the branch predictor control slice:
// index/tag widths, 2-bit direction counter encodings and the per-stage prediction record.
package bp_pkg;

  localparam int DEF_IDX_W = 10;
  localparam int DEF_TAG_W = 20;

  typedef enum logic [1:0] {
    CNT_SNT = 2'b00,
    CNT_WNT = 2'b01,
    CNT_WT  = 2'b10,
    CNT_ST  = 2'b11
  } cnt_e;

  typedef struct packed {
    logic        taken;
    logic [31:0] target;
  } pred_info_t;

  localparam pred_info_t PRED_NONE = '{taken: 1'b0, target: 32'h0000_0000};

  // Saturating step of a 2-bit direction counter.
  function automatic logic [1:0] sat_update(input logic [1:0] cnt, input logic taken);
    logic [1:0] res;
    case (cnt)
      CNT_SNT: res = taken ? CNT_WNT : CNT_SNT;
      CNT_WNT: res = taken ? CNT_WT  : CNT_SNT;
      CNT_WT:  res = taken ? CNT_ST  : CNT_WNT;
      CNT_ST:  res = taken ? CNT_ST  : CNT_WT;
      default: res = CNT_WNT;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/bp_counter_table.sv
// 2**IDX_W x 2-bit saturating direction counters: combinational read for IF,
// synchronous update/allocate port driven from EX.
module bp_counter_table
  import bp_pkg::*;
#(
  parameter int         IDX_W    = DEF_IDX_W,
  parameter logic [1:0] CNT_INIT = CNT_WNT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [IDX_W-1:0] rd_idx,
  output logic [1:0]       rd_cnt,
  input  logic             upd_en,
  input  logic [IDX_W-1:0] upd_idx,
  input  logic             upd_taken,
  input  logic             alloc_en
);

  localparam int ENTRIES = 1 << IDX_W;

  logic [1:0] cnt_r [ENTRIES];
  logic [1:0] wr_val_s;

  assign rd_cnt = cnt_r[rd_idx];

  // A fresh allocation starts weakly taken instead of stepping the old counter.
  always_comb begin
    wr_val_s = CNT_WNT;
    if (alloc_en) begin
      wr_val_s = CNT_WT;
    end else begin
      wr_val_s = sat_update(cnt_r[upd_idx], upd_taken);
    end
  end

  // Counter array storage.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        cnt_r[i] <= CNT_INIT;
      end
    end else if (upd_en) begin
      cnt_r[upd_idx] <= wr_val_s;
    end
  end

endmodule

// File: rtl/branch_predictor_ctrl.sv
// Branch prediction control around the external BTB: IF-side hit/next-PC, prediction
// pipeline to EX, mispredict redirect and BTB maintenance. Define BP_STATS_EN for stat counters.
module branch_predictor_ctrl
  import bp_pkg::*;
#(
  parameter int         IDX_W    = DEF_IDX_W,
  parameter int         TAG_W    = DEF_TAG_W,
  parameter logic [1:0] CNT_INIT = CNT_WNT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      if_pc,
  input  logic             stall,
  output logic [31:0]      next_pc,
  output logic [IDX_W-1:0] btb_r_addr,
  input  logic [TAG_W-1:0] btb_tag,
  input  logic             btb_vld,
  input  logic [31:0]      btb_target,
  output logic             btb_w_en,
  output logic [IDX_W-1:0] btb_w_addr,
  output logic [TAG_W-1:0] btb_w_tag,
  output logic [31:0]      btb_w_target,
  input  logic             ex_valid,
  input  logic             ex_is_branch,
  input  logic             ex_taken,
  input  logic [31:0]      ex_pc,
  input  logic [31:0]      ex_target,
  output logic             redirect,
  output logic [31:0]      redirect_pc
`ifdef BP_STATS_EN
  ,
  output logic [31:0]      stat_branches,
  output logic [31:0]      stat_mispredicts
`endif
);

  localparam int ENTRIES = 1 << IDX_W;

  logic [IDX_W-1:0]   if_idx_s;
  logic [TAG_W-1:0]   if_tag_s;
  logic [IDX_W-1:0]   ex_idx_s;
  logic [TAG_W-1:0]   ex_tag_s;
  logic [ENTRIES-1:0] vt_r;
  logic [1:0]         if_cnt_s;
  logic               hit_s;
  pred_info_t         if_pred_s;
  pred_info_t         id_pred_r;
  pred_info_t         ex_pred_r;
  logic               id_hit_r;
  logic               ex_hit_r;
  logic               mispredict_s;
  logic               upd_s;
  logic               alloc_s;
  logic               alias_s;

  assign if_idx_s   = if_pc[IDX_W+1:2];
  assign if_tag_s   = if_pc[31:32-TAG_W];
  assign ex_idx_s   = ex_pc[IDX_W+1:2];
  assign ex_tag_s   = ex_pc[31:32-TAG_W];
  assign btb_r_addr = if_idx_s;

  // The BTB valid bit is untrusted until we have written the entry ourselves.
  assign hit_s = vt_r[if_idx_s] & btb_vld & (btb_tag == if_tag_s);

  // IF-side prediction; target carries the BTB target on any hit so EX can
  // decide whether the entry already holds the resolved target.
  always_comb begin
    if_pred_s = PRED_NONE;
    if (hit_s) begin
      if_pred_s.taken  = if_cnt_s[1];
      if_pred_s.target = btb_target;
    end else begin
      if_pred_s = PRED_NONE;
    end
  end

  assign next_pc = if_pred_s.taken ? btb_target : (if_pc + 32'd4);

  // IF->ID->EX prediction stages: flush beats stall.
  always_ff @(posedge clk) begin
    if (rst) begin
      id_pred_r <= PRED_NONE;
      ex_pred_r <= PRED_NONE;
      id_hit_r  <= 1'b0;
      ex_hit_r  <= 1'b0;
    end else if (redirect) begin
      id_pred_r <= PRED_NONE;
      ex_pred_r <= PRED_NONE;
      id_hit_r  <= 1'b0;
      ex_hit_r  <= 1'b0;
    end else if (!stall) begin
      id_pred_r <= if_pred_s;
      ex_pred_r <= id_pred_r;
      id_hit_r  <= hit_s;
      ex_hit_r  <= id_hit_r;
    end
  end

  // EX-stage resolution check.
  always_comb begin
    mispredict_s = 1'b0;
    if (ex_valid) begin
      if (ex_is_branch) begin
        mispredict_s = (ex_taken != ex_pred_r.taken) |
                       (ex_taken & ex_pred_r.taken & (ex_target != ex_pred_r.target));
      end else begin
        mispredict_s = ex_pred_r.taken;
      end
    end else begin
      mispredict_s = 1'b0;
    end
  end

  assign redirect    = mispredict_s & ~rst;
  assign redirect_pc = (ex_taken & ex_is_branch) ? ex_target : (ex_pc + 32'd4);

  assign upd_s   = ex_valid & ex_is_branch & ~rst;
  assign alias_s = ex_valid & ~ex_is_branch & ex_pred_r.taken & ~rst;
  assign alloc_s = upd_s & ex_taken &
                   (~vt_r[ex_idx_s] | ~ex_hit_r | (ex_pred_r.target != ex_target));

  assign btb_w_en     = alloc_s;
  assign btb_w_addr   = ex_idx_s;
  assign btb_w_tag    = ex_tag_s;
  assign btb_w_target = ex_target;

  // Own valid table: set on allocation, dropped when a non-branch was predicted taken.
  always_ff @(posedge clk) begin
    if (rst) begin
      vt_r <= {ENTRIES{1'b0}};
    end else if (alloc_s) begin
      vt_r[ex_idx_s] <= 1'b1;
    end else if (alias_s) begin
      vt_r[ex_idx_s] <= 1'b0;
    end
  end

  bp_counter_table #(
    .IDX_W   (IDX_W),
    .CNT_INIT(CNT_INIT)
  ) u_cnt (
    .clk      (clk),
    .rst      (rst),
    .rd_idx   (if_idx_s),
    .rd_cnt   (if_cnt_s),
    .upd_en   (upd_s),
    .upd_idx  (ex_idx_s),
    .upd_taken(ex_taken),
    .alloc_en (alloc_s)
  );

`ifdef BP_STATS_EN
  // Free-running event counters; wrap naturally at 2**32.
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_branches    <= 32'd0;
      stat_mispredicts <= 32'd0;
    end else begin
      if (upd_s) begin
        stat_branches <= stat_branches + 32'd1;
      end
      if (redirect) begin
        stat_mispredicts <= stat_mispredicts + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_branch_predictor_ctrl.sv
// Self-checking bench for branch_predictor_ctrl: a behavioural BTB/predictor model checked
// every cycle, plus directed scenarios with literal expectations. Honours BP_STATS_EN.
module tb_branch_predictor_ctrl;

  localparam logic [31:0] FILL = 32'h0000_0008;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] if_pc;
  logic        stall;
  logic [31:0] next_pc;
  logic [9:0]  btb_r_addr;
  logic [19:0] btb_tag;
  logic        btb_vld;
  logic [31:0] btb_target;
  logic        btb_w_en;
  logic [9:0]  btb_w_addr;
  logic [19:0] btb_w_tag;
  logic [31:0] btb_w_target;
  logic        ex_valid;
  logic        ex_is_branch;
  logic        ex_taken;
  logic [31:0] ex_pc;
  logic [31:0] ex_target;
  logic        redirect;
  logic [31:0] redirect_pc;
`ifdef BP_STATS_EN
  logic [31:0] stat_branches;
  logic [31:0] stat_mispredicts;
`endif

  always #5 clk = ~clk;

  branch_predictor_ctrl dut (
    .clk(clk), .rst(rst), .if_pc(if_pc), .stall(stall), .next_pc(next_pc),
    .btb_r_addr(btb_r_addr), .btb_tag(btb_tag), .btb_vld(btb_vld), .btb_target(btb_target),
    .btb_w_en(btb_w_en), .btb_w_addr(btb_w_addr), .btb_w_tag(btb_w_tag),
    .btb_w_target(btb_w_target), .ex_valid(ex_valid), .ex_is_branch(ex_is_branch),
    .ex_taken(ex_taken), .ex_pc(ex_pc), .ex_target(ex_target),
    .redirect(redirect), .redirect_pc(redirect_pc)
`ifdef BP_STATS_EN
    , .stat_branches(stat_branches), .stat_mispredicts(stat_mispredicts)
`endif
  );

  // BTB array (environment) and predictor model state
  bit          btb_vld_mem    [1024];
  bit [19:0]   btb_tag_mem    [1024];
  bit [31:0]   btb_target_mem [1024];
  bit          vt_m [1024];
  bit [1:0]    ct_m [1024];
  int          m_br, m_mp;

  assign btb_vld    = btb_vld_mem[btb_r_addr];
  assign btb_tag    = btb_tag_mem[btb_r_addr];
  assign btb_target = btb_target_mem[btb_r_addr];

  // expected prediction held by the EX instruction, set by the stimulus
  logic        e_taken;
  logic [31:0] e_target;
  logic        chk_en = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_pred(input logic [31:0] pc, output logic tk,
                                     output logic [31:0] nxt, output logic [31:0] tgt);
    int  i;
    bit  hit;
    i   = int'(pc[11:2]);
    hit = vt_m[i] && btb_vld_mem[i] && (btb_tag_mem[i] == pc[31:12]);
    tk  = hit && (ct_m[i] >= 2'd2);
    tgt = btb_target_mem[i];
    nxt = tk ? btb_target_mem[i] : pc + 32'd4;
  endfunction

  // pending model updates, decided at negedge, applied at the next posedge
  bit        p_upd, p_alloc, p_alias, p_redir, p_taken;
  int        p_idx;
  logic      f_tk, x_redir, x_hitm, x_alloc;
  logic [31:0] f_nx, f_tg;

  // compare process: every cycle
  always @(negedge clk) begin
    model_pred(if_pc, f_tk, f_nx, f_tg);
    p_idx   = int'(ex_pc[11:2]);
    x_redir = 1'b0;
    if (!rst && ex_valid)
      x_redir = ex_is_branch ? ((ex_taken != e_taken) || (ex_taken && e_taken && ex_target != e_target))
                             : e_taken;
    p_upd   = !rst && ex_valid && ex_is_branch;
    x_hitm  = vt_m[p_idx] && btb_vld_mem[p_idx] && btb_tag_mem[p_idx] == ex_pc[31:12]
              && btb_target_mem[p_idx] == ex_target;
    x_alloc = p_upd && ex_taken && !x_hitm;
    p_alloc = x_alloc;
    p_alias = !rst && ex_valid && !ex_is_branch && e_taken;
    p_redir = x_redir;
    p_taken = ex_taken;
    if (chk_en) begin
      chk("next_pc", next_pc, f_nx);
      chk("btb_r_addr", {22'd0, btb_r_addr}, {22'd0, if_pc[11:2]});
      chk("redirect", {31'd0, redirect}, {31'd0, x_redir});
      if (x_redir) chk("redirect_pc", redirect_pc,
                       (ex_taken && ex_is_branch) ? ex_target : ex_pc + 32'd4);
      chk("btb_w_en", {31'd0, btb_w_en}, {31'd0, x_alloc});
      if (x_alloc) begin
        chk("btb_w_addr", {22'd0, btb_w_addr}, {22'd0, ex_pc[11:2]});
        chk("btb_w_tag", {12'd0, btb_w_tag}, {12'd0, ex_pc[31:12]});
        chk("btb_w_target", btb_w_target, ex_target);
      end
`ifdef BP_STATS_EN
      chk("stat_branches", stat_branches, m_br);
      chk("stat_mispredicts", stat_mispredicts, m_mp);
`endif
    end
  end

  // model state and BTB array update
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 1024; i++) begin
        vt_m[i]           <= 1'b0;
        ct_m[i]           <= 2'b01;
        btb_vld_mem[i]    <= 1'b1;
        btb_tag_mem[i]    <= 20'h00000;
        btb_target_mem[i] <= 32'h0000_8000 + (32'(i) << 2);
      end
      m_br <= 0;
      m_mp <= 0;
    end else begin
      if (p_upd) begin
        if (p_alloc) ct_m[p_idx] <= 2'b10;
        else if (p_taken) ct_m[p_idx] <= (ct_m[p_idx] == 2'd3) ? 2'd3 : ct_m[p_idx] + 2'd1;
        else ct_m[p_idx] <= (ct_m[p_idx] == 2'd0) ? 2'd0 : ct_m[p_idx] - 2'd1;
        m_br <= m_br + 1;
      end
      if (p_alloc) vt_m[p_idx] <= 1'b1;
      else if (p_alias) vt_m[p_idx] <= 1'b0;
      if (p_redir) m_mp <= m_mp + 1;
      if (btb_w_en) begin
        btb_vld_mem[btb_w_addr]    <= 1'b1;
        btb_tag_mem[btb_w_addr]    <= btb_w_tag;
        btb_target_mem[btb_w_addr] <= btb_w_target;
      end
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic fetch(input logic [31:0] pc, output logic [31:0] nx);
    if_pc = pc; ex_valid = 1'b0; stall = 1'b0;
    @(negedge clk);
    nx = next_pc;
    next_cycle();
  endtask

  // one instruction: fetch, one filler cycle, resolve in EX
  task automatic txn(input logic [31:0] fpc, input logic br, input logic tk,
                     input logic [31:0] epc, input logic [31:0] etgt,
                     output logic [31:0] fnx, output logic rd, output logic [31:0] rpc,
                     output logic wen, output logic [31:0] wad);
    logic        ptk;
    logic [31:0] pnx, ptg;
    if_pc = fpc; ex_valid = 1'b0; stall = 1'b0;
    model_pred(fpc, ptk, pnx, ptg);
    @(negedge clk);
    fnx = next_pc;
    next_cycle();
    if_pc = FILL;
    next_cycle();
    ex_valid = 1'b1; ex_is_branch = br; ex_taken = tk; ex_pc = epc; ex_target = etgt;
    e_taken = ptk; e_target = ptg;
    @(negedge clk);
    rd = redirect; rpc = redirect_pc; wen = btb_w_en; wad = {22'd0, btb_w_addr};
    next_cycle();
    ex_valid = 1'b0;
  endtask

  logic [31:0] fnx, rpc, wad;
  logic        rd, wen;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    // T1: reset with a taken branch presented in EX and a stale BTB hit
    rst = 1'b1; if_pc = 32'h100; stall = 1'b0;
    ex_valid = 1'b1; ex_is_branch = 1'b1; ex_taken = 1'b1; ex_pc = 32'h100; ex_target = 32'h300;
    e_taken = 1'b0; e_target = 32'h0;
    next_cycle();
    chk_en = 1'b1;
    @(negedge clk);
    chk("T1 next_pc", next_pc, 32'h104);
    chk("T1 redirect", {31'd0, redirect}, 32'd0);
    chk("T1 btb_w_en", {31'd0, btb_w_en}, 32'd0);
    next_cycle();
    rst = 1'b0; ex_valid = 1'b0; if_pc = FILL;
    next_cycle();

    // T2: cold taken branch
    txn(32'h200, 1'b1, 1'b1, 32'h200, 32'h400, fnx, rd, rpc, wen, wad);
    chk("T2 fetch", fnx, 32'h204);
    chk("T2 redirect", {31'd0, rd}, 32'd1);
    chk("T2 redirect_pc", rpc, 32'h400);
    chk("T2 w_en", {31'd0, wen}, 32'd1);
    chk("T2 w_addr", wad, 32'h080);
    fetch(32'h200, fnx);
    chk("T2 refetch", fnx, 32'h400);

    // T3: wrong direction
    txn(32'h200, 1'b1, 1'b0, 32'h200, 32'h204, fnx, rd, rpc, wen, wad);
    chk("T3 fetch", fnx, 32'h400);
    chk("T3 redirect", {31'd0, rd}, 32'd1);
    chk("T3 redirect_pc", rpc, 32'h204);
    chk("T3 model ct", {30'd0, ct_m[128]}, 32'd1);
    fetch(32'h200, fnx);
    chk("T3 refetch", fnx, 32'h204);

    // T4: saturation then one not-taken
    for (int k = 0; k < 5; k++) begin
      txn(32'h200, 1'b1, 1'b1, 32'h200, 32'h400, fnx, rd, rpc, wen, wad);
      chk("T4 redirect", {31'd0, rd}, (k == 0) ? 32'd1 : 32'd0);
      chk("T4 w_en", {31'd0, wen}, 32'd0);
    end
    chk("T4 model ct sat", {30'd0, ct_m[128]}, 32'd3);
    txn(32'h200, 1'b1, 1'b0, 32'h200, 32'h204, fnx, rd, rpc, wen, wad);
    chk("T4 nt redirect_pc", rpc, 32'h204);
    chk("T4 model ct", {30'd0, ct_m[128]}, 32'd2);
    fetch(32'h200, fnx);
    chk("T4 still taken", fnx, 32'h400);

    // T5: non-branch at aliasing PC carries a taken prediction
    txn(32'h200, 1'b0, 1'b0, 32'h1200, 32'h0, fnx, rd, rpc, wen, wad);
    chk("T5 redirect", {31'd0, rd}, 32'd1);
    chk("T5 redirect_pc", rpc, 32'h1204);
    chk("T5 w_en", {31'd0, wen}, 32'd0);
    chk("T5 model vt", {31'd0, vt_m[128]}, 32'd0);
    fetch(32'h200, fnx);
    chk("T5 miss", fnx, 32'h204);

    // T6: retrain, then stall coinciding with redirect must flush the taken ID stage
    txn(32'h200, 1'b1, 1'b1, 32'h200, 32'h400, fnx, rd, rpc, wen, wad);
    chk("T6 realloc", {31'd0, wen}, 32'd1);
    if_pc = 32'h200; ex_valid = 1'b0;
    next_cycle();
    if_pc = FILL; stall = 1'b1;
    ex_valid = 1'b1; ex_is_branch = 1'b1; ex_taken = 1'b1; ex_pc = 32'h600; ex_target = 32'h800;
    e_taken = 1'b0; e_target = 32'h0;
    @(negedge clk);
    chk("T6 redirect", {31'd0, redirect}, 32'd1);
    chk("T6 redirect_pc", redirect_pc, 32'h800);
    chk("T6 w_addr", {22'd0, btb_w_addr}, 32'h180);
    next_cycle();
    stall = 1'b0; ex_valid = 1'b0;
    next_cycle();
    ex_valid = 1'b1; ex_is_branch = 1'b0; ex_taken = 1'b0; ex_pc = 32'h200; ex_target = 32'h0;
    @(negedge clk);
    chk("T6 flushed", {31'd0, redirect}, 32'd0);
    next_cycle();
    ex_valid = 1'b0;

    // stall without redirect holds the prediction until EX
    if_pc = 32'h200;
    next_cycle();
    if_pc = FILL; stall = 1'b1;
    next_cycle();
    next_cycle();
    stall = 1'b0;
    next_cycle();
    ex_valid = 1'b1; ex_is_branch = 1'b1; ex_taken = 1'b1; ex_pc = 32'h200; ex_target = 32'h400;
    e_taken = 1'b1; e_target = 32'h400;
    @(negedge clk);
    chk("stall hold", {31'd0, redirect}, 32'd0);
    next_cycle();
    ex_valid = 1'b0;
    next_cycle();
`ifdef BP_STATS_EN
    @(negedge clk);
    chk("stat_branches total", stat_branches, 32'd11);
    chk("stat_mispredicts total", stat_mispredicts, 32'd7);
`endif
    next_cycle();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
